// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Multiply and MT* commit in the issue cycle.
// Divide stalls EX for 33 cycles (issue + 32 radix-2 steps) and commits on the following DONE cycle.

`ifndef EXE_MFHI_OP
`define EXE_MFHI_OP  8'b00010000
`endif
`ifndef EXE_MTHI_OP
`define EXE_MTHI_OP  8'b00010001
`endif
`ifndef EXE_MFLO_OP
`define EXE_MFLO_OP  8'b00010010
`endif
`ifndef EXE_MTLO_OP
`define EXE_MTLO_OP  8'b00010011
`endif
`ifndef EXE_MULT_OP
`define EXE_MULT_OP  8'b00011000
`endif
`ifndef EXE_MULTU_OP
`define EXE_MULTU_OP 8'b00011001
`endif
`ifndef EXE_DIV_OP
`define EXE_DIV_OP   8'b00011010
`endif
`ifndef EXE_DIVU_OP
`define EXE_DIVU_OP  8'b00011011
`endif

module hilo_muldiv_unit #(
   parameter int DIV_ITERS = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        en,
   input  logic [7:0]  alucontrol,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] rdata,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam logic [7:0] OP_MFHI  = `EXE_MFHI_OP;
   localparam logic [7:0] OP_MTHI  = `EXE_MTHI_OP;
   localparam logic [7:0] OP_MFLO  = `EXE_MFLO_OP;
   localparam logic [7:0] OP_MTLO  = `EXE_MTLO_OP;
   localparam logic [7:0] OP_MULT  = `EXE_MULT_OP;
   localparam logic [7:0] OP_MULTU = `EXE_MULTU_OP;
   localparam logic [7:0] OP_DIV   = `EXE_DIV_OP;
   localparam logic [7:0] OP_DIVU  = `EXE_DIVU_OP;
   localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      state_q;
   logic [4:0]  cnt_q;
   logic [31:0] hi_q, lo_q;
   logic [31:0] rem_q, quo_q, dvs_q;
   logic        qneg_q, rneg_q;

   logic        is_div, is_sdiv, div_start;
   logic [63:0] prod_s, prod_u;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [32:0] shifted, trial;
   logic        fits;
   logic [31:0] rem_step, quo_step, rem_fin, quo_fin;

   assign is_sdiv   = (alucontrol == OP_DIV);
   assign is_div    = is_sdiv | (alucontrol == OP_DIVU);
   assign div_start = en & ~flush & is_div & (src_b != 32'd0) & (state_q == S_IDLE);

   assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
   assign prod_u = {32'd0, src_a} * {32'd0, src_b};

   // Signed divide runs on magnitudes; 0x80000000 negates to itself, which is the correct 2^31 magnitude.
   assign a_neg = is_sdiv & src_a[31];
   assign b_neg = is_sdiv & src_b[31];
   assign a_mag = a_neg ? -src_a : src_a;
   assign b_mag = b_neg ? -src_b : src_b;

   assign shifted  = {rem_q, quo_q[31]};
   assign trial    = shifted - {1'b0, dvs_q};
   assign fits     = (shifted >= {1'b0, dvs_q});
   assign rem_step = fits ? trial[31:0] : shifted[31:0];
   assign quo_step = {quo_q[30:0], fits};
   assign quo_fin  = qneg_q ? -quo_q : quo_q;
   assign rem_fin  = rneg_q ? -rem_q : rem_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else if (flush) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (en) begin
                  case (alucontrol)
                     OP_MULT:  {hi_q, lo_q} <= prod_s;
                     OP_MULTU: {hi_q, lo_q} <= prod_u;
                     OP_MTHI:  hi_q <= src_a;
                     OP_MTLO:  lo_q <= src_a;
                     OP_DIV, OP_DIVU: begin
                        if (src_b != 32'd0) begin
                           rem_q   <= '0;
                           quo_q   <= a_mag;
                           dvs_q   <= b_mag;
                           qneg_q  <= a_neg ^ b_neg;
                           rneg_q  <= a_neg;
                           cnt_q   <= '0;
                           state_q <= S_RUN;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               rem_q <= rem_step;
               quo_q <= quo_step;
               if (cnt_q == LAST_ITER) begin
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + 5'd1;
               end
            end
            S_DONE: begin
               hi_q    <= rem_fin;
               lo_q    <= quo_fin;
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign stall = resetn & ~flush & ((state_q == S_RUN) | div_start);

   always_comb begin
      rdata = 32'd0;
      if (alucontrol == OP_MFHI) rdata = hi_q;
      else if (alucontrol == OP_MFLO) rdata = lo_q;
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: table of single-cycle ops, then hand sequences for divide, flush and reset.
module tb_hilo_muldiv_unit;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_MFHI  = 8'b00010000;
   localparam logic [7:0] OP_MTHI  = 8'b00010001;
   localparam logic [7:0] OP_MFLO  = 8'b00010010;
   localparam logic [7:0] OP_MTLO  = 8'b00010011;
   localparam logic [7:0] OP_MULT  = 8'b00011000;
   localparam logic [7:0] OP_MULTU = 8'b00011001;
   localparam logic [7:0] OP_DIV   = 8'b00011010;
   localparam logic [7:0] OP_DIVU  = 8'b00011011;

   logic        clk = 1'b0;
   logic        resetn;
   logic        en;
   logic [7:0]  alucontrol;
   logic [31:0] src_a, src_b;
   logic        flush;
   logic        stall;
   logic [31:0] rdata, hi_o, lo_o;

   int n_vec = 0;
   int n_err = 0;

   hilo_muldiv_unit #(.DIV_ITERS(32)) dut (
      .clk(clk), .resetn(resetn), .en(en), .alucontrol(alucontrol),
      .src_a(src_a), .src_b(src_b), .flush(flush), .stall(stall),
      .rdata(rdata), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic        en;
      logic        fl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] rd;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [7:0] op, input logic e, input logic [31:0] a, input logic [31:0] b);
      alucontrol = op;
      en         = e;
      src_a      = a;
      src_b      = b;
   endtask

   // Issues a divide held with en=1, counts stall cycles, then checks the committed result via MFLO.
   task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
      int  n;
      bit  done;
      n    = 0;
      done = 0;
      @(posedge clk); #1;
      drive(op, 1'b1, a, b);
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (stall) n++;
         else done = 1;
         if (!done) begin
            @(posedge clk); #1;
            src_a = 32'hDEADBEEF ^ i;
            src_b = 32'(i);
         end
      end
      chk({name, " stall_cycles"}, 32'(n), 32'd33);
      @(posedge clk); #1;
      drive(OP_MFLO, 1'b1, 32'd0, 32'd0);
      @(negedge clk);
      chk({name, " hi"}, hi_o, ehi);
      chk({name, " lo"}, lo_o, elo);
      chk({name, " mflo"}, rdata, elo);
      @(posedge clk); #1;
      drive(OP_NOP, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      int nst;
      tbl[0]  = '{OP_MULT,  1'b1, 1'b0, 32'hFFFFFFFE, 32'd3,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA};
      tbl[1]  = '{OP_MFHI,  1'b1, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFA};
      tbl[2]  = '{OP_MULTU, 1'b1, 1'b0, 32'hFFFFFFFE, 32'd3,        32'h0,        32'h00000002, 32'hFFFFFFFA};
      tbl[3]  = '{OP_MFLO,  1'b1, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFA, 32'h00000002, 32'hFFFFFFFA};
      tbl[4]  = '{OP_MTHI,  1'b1, 1'b0, 32'h1234,     32'h0,        32'h0,        32'h00001234, 32'hFFFFFFFA};
      tbl[5]  = '{OP_MTLO,  1'b1, 1'b0, 32'h5678,     32'h0,        32'h0,        32'h00001234, 32'h00005678};
      tbl[6]  = '{OP_DIV,   1'b1, 1'b0, 32'd55,       32'd0,        32'h0,        32'h00001234, 32'h00005678};
      tbl[7]  = '{OP_DIVU,  1'b1, 1'b0, 32'd55,       32'd0,        32'h0,        32'h00001234, 32'h00005678};
      tbl[8]  = '{OP_MULT,  1'b1, 1'b1, 32'd5,        32'd5,        32'h0,        32'h00001234, 32'h00005678};
      tbl[9]  = '{OP_MTHI,  1'b0, 1'b0, 32'hFFFF,     32'h0,        32'h0,        32'h00001234, 32'h00005678};
      tbl[10] = '{8'h25,    1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h00001234, 32'h00005678};
      tbl[11] = '{OP_MULT,  1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h0,        32'h40000000, 32'h00000000};
      tbl[12] = '{OP_MULT,  1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h00000000, 32'h00000001};
      tbl[13] = '{OP_MULTU, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFE, 32'h00000001};
      tbl[14] = '{OP_MFHI,  1'b1, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000001};

      resetn = 1'b0;
      flush  = 1'b0;
      drive(OP_NOP, 1'b0, 32'd0, 32'd0);
      #12;
      chk("reset hi", hi_o, 32'd0);
      chk("reset lo", lo_o, 32'd0);
      chk("reset stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].op, tbl[i].en, tbl[i].a, tbl[i].b);
         flush = tbl[i].fl;
         @(negedge clk);
         chk($sformatf("row%0d stall", i), {31'd0, stall}, 32'd0);
         chk($sformatf("row%0d rdata", i), rdata, tbl[i].rd);
         @(posedge clk); #1;
         chk($sformatf("row%0d hi", i), hi_o, tbl[i].hi);
         chk($sformatf("row%0d lo", i), lo_o, tbl[i].lo);
      end
      flush = 1'b0;
      drive(OP_NOP, 1'b0, 32'd0, 32'd0);

      run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
      run_div("div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_div("div_7_m2",   OP_DIV,  32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
      run_div("div_min_m1", OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

      // Flush in RUN cycle 10: divide abandoned, HI/LO keep 0 / 0x80000000.
      @(posedge clk); #1;
      drive(OP_DIVU, 1'b1, 32'd100, 32'd7);
      @(negedge clk);
      chk("flush issue stall", {31'd0, stall}, 32'd1);
      nst = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (k == 10) flush = 1'b1;
         @(negedge clk);
         if (k < 10 && stall) nst++;
         if (k == 10) chk("flush cycle stall", {31'd0, stall}, 32'd0);
      end
      chk("flush pre-run stalls", 32'(nst), 32'd9);
      @(posedge clk); #1;
      flush = 1'b0;
      drive(OP_NOP, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      chk("post flush stall", {31'd0, stall}, 32'd0);
      repeat (40) @(posedge clk);
      #1;
      chk("post flush hi", hi_o, 32'd0);
      chk("post flush lo", lo_o, 32'h80000000);
      run_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3);

      // Reset asserted in RUN cycle 20.
      @(posedge clk); #1;
      drive(OP_MTHI, 1'b1, 32'hCAFEF00D, 32'd0);
      @(posedge clk); #1;
      chk("pre reset hi", hi_o, 32'hCAFEF00D);
      drive(OP_DIVU, 1'b1, 32'd100, 32'd7);
      repeat (20) @(posedge clk);
      #1;
      chk("run20 stall", {31'd0, stall}, 32'd1);
      resetn = 1'b0;
      #1;
      chk("async reset stall", {31'd0, stall}, 32'd0);
      chk("async reset hi", hi_o, 32'd0);
      chk("async reset lo", lo_o, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      drive(OP_NOP, 1'b0, 32'd0, 32'd0);
      @(posedge clk); #1;
      drive(OP_MTLO, 1'b1, 32'hA5A5A5A5, 32'd0);
      @(posedge clk); #1;
      drive(OP_MFLO, 1'b1, 32'd0, 32'd0);
      @(negedge clk);
      chk("after reset mflo", rdata, 32'hA5A5A5A5);
      chk("after reset hi", hi_o, 32'd0);
      chk("after reset stall", {31'd0, stall}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execute-stage consumer of the 8-bit alucontrol code produced by the instruction decoder.
- Executes MULT, MULTU, DIV, DIVU, MTHI, MTLO and owns the architectural HI/LO registers.
- Returns HI/LO for MFHI/MFLO.
- Multiply commits in one cycle; divide is a 32-iteration radix-2 sequential divider that stalls the pipeline until it completes.

Parameters:
- DIV_ITERS, 32, number of divider iteration cycles; fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- en  in  1  valid instruction present in EX this cycle
- alucontrol  in  8  decoded operation code (codebase `EXE_*_OP encodings)
- src_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
- src_b  in  32  rt operand (divisor / multiplier)
- flush  in  1  exception/eret flush of EX; aborts any operation
- stall  out  1  hold IF..EX while divide is in progress
- rdata  out  32  HI for `EXE_MFHI_OP, LO for `EXE_MFLO_OP, else 0
- hi_o  out  32  current HI register
- lo_o  out  32  current LO register

Behaviour:
- Reset (resetn=0, asynchronous):
  - HI=0, LO=0, state=IDLE, counter=0, stall=0.
- Operations are acted on only when en=1 and flush=0.
- Other alucontrol codes are ignored: no state change, stall=0.
- `EXE_MULT_OP: {HI,LO} <= signed 64-bit product at the end of the issue cycle; stall=0.
- `EXE_MULTU_OP: same, unsigned.
- `EXE_MTHI_OP: HI <= src_a at the end of the issue cycle.
- `EXE_MTLO_OP: LO <= src_a at the end of the issue cycle.
- rdata/hi_o/lo_o: combinational from the registers.
- An MFLO issued the cycle after a MULT sees the new value; there is no internal forwarding within the same cycle.
- Divide FSM states: IDLE, RUN, DONE.
  - IDLE:
    - en & DIV/DIVU & src_b!=0: latch operands, counter=0, go RUN; stall=1 combinationally in this issue cycle.
    - en & DIV/DIVU & src_b==0: stay IDLE, stall=0, HI/LO unchanged.
  - RUN:
    - One restoring shift-subtract step per cycle on magnitudes; stall=1.
    - After DIV_ITERS steps (counter==31 at the edge), go DONE.
  - DONE:
    - stall=0.
    - At the end of the cycle: HI <= remainder, LO <= quotient, go IDLE.
    - en is ignored in DONE because the held DIV instruction is still present.
- Timing: stall is high for 33 consecutive cycles (issue + 32 RUN). The DIV occupies EX for 34 cycles, and the result is visible the cycle after DONE.
- Signed DIV rules:
  - Divide |a| by |b|.
  - Quotient is negated if the sign bits differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (no trap).
- DIVU: unsigned 32/32; quotient and remainder raw.
- flush:
  - In any state, synchronously return to IDLE.
  - No HI/LO write, including when flush coincides with DONE.
  - stall is forced 0 combinationally in the flush cycle.
  - Flush takes priority over en (MULT/MT* in a flushed cycle do not commit).
- Operand latching: src_a/src_b changes during RUN have no effect.
- Reset mid-divide: immediate IDLE, HI=LO=0.

Test Plan:
- MULT src_a=0xFFFFFFFE(-2), src_b=3 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA, stall never high. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIVU 100/7 held with en=1 -> stall high exactly 33 cycles, then low 1 cycle; afterwards LO=14, HI=2; MFLO rdata=14.
- DIV signed sign cases:
  - -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - 7/-2 -> LO=0xFFFFFFFD, HI=1.
  - 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV with src_b=0 after MTHI 0x1234, MTLO 0x5678 -> stall stays 0; HI=0x1234, LO=0x5678 unchanged.
- DIVU 100/7 with flush pulsed at RUN cycle 10 -> stall drops in that cycle, state IDLE, HI/LO keep prior values. A new DIVU 9/3 then yields LO=3, HI=0.
- resetn pulled low at RUN cycle 20 -> stall=0, HI=LO=0 asynchronously. After release, MTLO 0xA5A5A5A5 -> rdata for MFLO = 0xA5A5A5A5.
